// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for a 5-stage pipeline: per-register latency scoreboard,
// E-stage and D-stage forward selects, D-stall/E-bubble generation and a stall counter.
module hazard_scoreboard #(
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MAX_LAT = 3,
  parameter int unsigned PERF_W  = 16,
  localparam int unsigned LAT_W  = $clog2(MAX_LAT + 1)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        issue_valid,
  input  logic                        issue_we,
  input  logic [REG_AW-1:0]           issue_dst,
  input  logic [LAT_W-1:0]            issue_lat,
  input  logic [NUM_SRC*REG_AW-1:0]   src_d,
  input  logic [NUM_SRC-1:0]          src_d_use,
  input  logic [NUM_SRC-1:0]          src_d_early,
  input  logic [NUM_SRC*REG_AW-1:0]   src_e,
  input  logic                        reg_write_m,
  input  logic [REG_AW-1:0]           write_reg_m,
  input  logic                        reg_write_w,
  input  logic [REG_AW-1:0]           write_reg_w,
  output logic [NUM_SRC*2-1:0]        fwd_e,
  output logic [NUM_SRC-1:0]          fwd_d,
  output logic                        stall_d,
  output logic                        flush_e,
  output logic [PERF_W-1:0]           stall_count
);

  localparam int unsigned NREG = 1 << REG_AW;

  logic [LAT_W-1:0]  cnt [NREG];
  logic              e_we;
  logic [REG_AW-1:0] e_dst;
  logic [PERF_W-1:0] count_q;
  logic [NUM_SRC-1:0] hazard;

  logic              issue_rec;
  logic [LAT_W-1:0]  lat_clamp;
  logic              m_wr;
  logic              w_wr;

  assign issue_rec = issue_valid & issue_we & (issue_dst != '0);
  assign lat_clamp = (issue_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : issue_lat;
  assign m_wr      = reg_write_m & (write_reg_m != '0);
  assign w_wr      = reg_write_w & (write_reg_w != '0);

  // Scoreboard: newest writer overrides the countdown; register 0 stays clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(NREG); r++) cnt[r] <= '0;
      e_we  <= 1'b0;
      e_dst <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < int'(NREG); r++) begin
        if (issue_rec && (issue_dst == REG_AW'(r)))
          cnt[r] <= lat_clamp;
        else if (cnt[r] != '0)
          cnt[r] <= cnt[r] - LAT_W'(1);
      end
      e_we  <= issue_rec;
      e_dst <= issue_dst;
    end
  end

  // Per-port forwarding and hazard detection.
  for (genvar i = 0; i < int'(NUM_SRC); i++) begin : g_port
    logic [REG_AW-1:0] se;
    logic [REG_AW-1:0] sd;
    logic              busy;
    logic              e_hit;

    assign se    = src_e[i*REG_AW +: REG_AW];
    assign sd    = src_d[i*REG_AW +: REG_AW];
    assign busy  = (cnt[sd] != '0);
    assign e_hit = e_we & (e_dst == sd);

    assign fwd_e[2*i +: 2] = (m_wr && write_reg_m == se) ? 2'b10 :
                             (w_wr && write_reg_w == se) ? 2'b01 : 2'b00;
    assign fwd_d[i]  = src_d_early[i] & m_wr & (write_reg_m == sd);
    // Early consumers also wait out a producer still sitting in E.
    assign hazard[i] = src_d_use[i] & (sd != '0) & (busy | (src_d_early[i] & e_hit));
  end

  assign stall_d     = |hazard;
  assign flush_e     = stall_d;
  assign stall_count = count_q;

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count_q <= '0;
    else if (stall_d && (count_q != '1))
      count_q <= count_q + PERF_W'(1);
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed pipeline scenarios plus random traffic,
// checked against a ready-time model of register availability.
module tb_hazard_scoreboard;

  localparam int NS = 2;
  localparam int AW = 5;
  localparam int PW = 4;
  localparam int SMAX = (1 << PW) - 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           issue_valid, issue_we;
  logic [AW-1:0]  issue_dst;
  logic [1:0]     issue_lat;
  logic [NS*AW-1:0] src_d, src_e;
  logic [NS-1:0]  src_d_use, src_d_early;
  logic           reg_write_m, reg_write_w;
  logic [AW-1:0]  write_reg_m, write_reg_w;
  logic [NS*2-1:0] fwd_e;
  logic [NS-1:0]  fwd_d;
  logic           stall_d, flush_e;
  logic [PW-1:0]  stall_count;

  int tests = 0;
  int fails = 0;

  // Model: cycle at which each register's result becomes forwardable.
  int cyc = 0;
  int ready [32];
  bit m_ewe;
  int m_edst;
  int m_sc;

  hazard_scoreboard #(.NUM_SRC(NS), .REG_AW(AW), .MAX_LAT(3), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_we(issue_we), .issue_dst(issue_dst), .issue_lat(issue_lat),
    .src_d(src_d), .src_d_use(src_d_use), .src_d_early(src_d_early), .src_e(src_e),
    .reg_write_m(reg_write_m), .write_reg_m(write_reg_m),
    .reg_write_w(reg_write_w), .write_reg_w(write_reg_w),
    .fwd_e(fwd_e), .fwd_d(fwd_d), .stall_d(stall_d), .flush_e(flush_e),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int r = 0; r < 32; r++) ready[r] = 0;
    m_ewe = 0; m_edst = 0; m_sc = 0;
  endtask

  function automatic int sd(int i);
    return int'(src_d[i*AW +: AW]);
  endfunction

  function automatic bit m_hazard(int i);
    int r = sd(i);
    if (!src_d_use[i] || r == 0) return 0;
    if (cyc < ready[r]) return 1;
    return src_d_early[i] && m_ewe && (m_edst == r);
  endfunction

  function automatic bit m_stall();
    bit s = 0;
    for (int i = 0; i < NS; i++) s |= m_hazard(i);
    return s;
  endfunction

  task automatic check_all();
    logic [NS*2-1:0] efe;
    logic [NS-1:0]   efd;
    bit              est;
    #1;
    efe = '0; efd = '0;
    for (int i = 0; i < NS; i++) begin
      int s = int'(src_e[i*AW +: AW]);
      if (reg_write_m && write_reg_m != 0 && int'(write_reg_m) == s) efe[2*i +: 2] = 2'b10;
      else if (reg_write_w && write_reg_w != 0 && int'(write_reg_w) == s) efe[2*i +: 2] = 2'b01;
      efd[i] = src_d_early[i] && reg_write_m && write_reg_m != 0 && int'(write_reg_m) == sd(i);
    end
    est = m_stall();
    chk("stall_d", 32'(stall_d), 32'(est));
    chk("flush_e", 32'(flush_e), 32'(est));
    chk("fwd_e", 32'(fwd_e), 32'(efe));
    chk("fwd_d", 32'(fwd_d), 32'(efd));
    chk("stall_count", 32'(stall_count), 32'(m_sc));
  endtask

  task automatic tick();
    if (m_stall() && m_sc < SMAX) m_sc++;
    @(posedge clk);
    cyc++;
    if (issue_valid && issue_we && issue_dst != 0) ready[issue_dst] = cyc + int'(issue_lat);
    m_ewe = issue_valid && issue_we && issue_dst != 0;
    m_edst = int'(issue_dst);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_we = 0; issue_dst = '0; issue_lat = '0;
    src_d = '0; src_d_use = '0; src_d_early = '0; src_e = '0;
    reg_write_m = 0; write_reg_m = '0; reg_write_w = 0; write_reg_w = '0;
  endtask

  task automatic issue(input int dst, input int lat);
    issue_valid = 1; issue_we = 1; issue_dst = AW'(dst); issue_lat = 2'(lat);
  endtask

  initial begin
    int sc0;
    m_reset();
    idle();
    reset = 1;
    #2 check_all();
    reset = 0;

    // Load (lat 1) to $8, then add $9,$8,$8: one stall, then W forwarding on both ports.
    issue(8, 1); check_all(); tick();
    idle(); src_d = {5'd8, 5'd8}; src_d_use = 2'b11;
    check_all(); chk("ld_use_stall", 32'(stall_d), 32'd1); tick();
    check_all(); chk("ld_use_release", 32'(stall_d), 32'd0);
    issue(9, 0); reg_write_m = 1; write_reg_m = 5'd8; tick();
    idle(); src_e = {5'd8, 5'd8}; reg_write_w = 1; write_reg_w = 5'd8;
    check_all(); chk("ld_use_fwd_w", 32'(fwd_e), 32'h5); tick();

    // add $8 then beq $8,$0: one stall, then early forward from M on port 0 only.
    idle(); issue(8, 0); check_all(); tick();
    idle(); src_d = {5'd0, 5'd8}; src_d_use = 2'b11; src_d_early = 2'b11;
    check_all(); chk("alu_br_stall", 32'(stall_d), 32'd1); tick();
    reg_write_m = 1; write_reg_m = 5'd8;
    check_all(); chk("alu_br_fwd_d", 32'(fwd_d), 32'h1); chk("alu_br_go", 32'(stall_d), 32'd0);
    tick();

    // Lat-3 write to $4 with a dependent in D: three stalls, counter +3.
    idle(); issue(4, 3); check_all(); tick();
    idle(); src_d = {5'd0, 5'd4}; src_d_use = 2'b01;
    sc0 = int'(stall_count);
    for (int k = 0; k < 3; k++) begin
      check_all(); chk("mul_stall", 32'(stall_d), 32'd1); tick();
    end
    check_all(); chk("mul_release", 32'(stall_d), 32'd0);
    chk("mul_count", 32'(stall_count), 32'(sc0 + 3));
    tick();

    // M beats W for the same register; register 0 never forwards.
    idle(); src_e = {5'd7, 5'd7}; reg_write_m = 1; write_reg_m = 5'd7; reg_write_w = 1; write_reg_w = 5'd7;
    check_all(); chk("m_over_w", 32'(fwd_e), 32'hA);
    src_e = '0; write_reg_m = '0; write_reg_w = '0;
    check_all(); chk("r0_no_fwd", 32'(fwd_e), 32'h0); tick();

    // WAW: a lat-0 write right after a lat-3 write to $6 clears the wait.
    idle(); issue(6, 3); check_all(); tick();
    issue(6, 0); check_all(); tick();
    idle(); src_d = {5'd6, 5'd6}; src_d_use = 2'b11;
    check_all(); chk("waw_no_stall", 32'(stall_d), 32'd0); tick();

    // Asynchronous reset while stalled on $5 (two cycles left).
    idle(); issue(5, 2); check_all(); tick();
    idle(); src_d = {5'd0, 5'd5}; src_d_use = 2'b01;
    check_all(); chk("pre_reset_stall", 32'(stall_d), 32'd1);
    #2 reset = 1;
    #1 m_reset();
    chk("async_rst_stall", 32'(stall_d), 32'd0);
    chk("async_rst_count", 32'(stall_count), 32'd0);
    check_all();
    reset = 0;
    check_all(); tick();

    // Random traffic; issue is mostly suppressed while stalled, occasionally not.
    for (int n = 0; n < 800; n++) begin
      idle();
      src_d = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      src_e = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      src_d_use = 2'($urandom); src_d_early = 2'($urandom);
      reg_write_m = 1'($urandom); write_reg_m = AW'($urandom_range(0, 7));
      reg_write_w = 1'($urandom); write_reg_w = AW'($urandom_range(0, 7));
      issue_we = 1'($urandom); issue_dst = AW'($urandom_range(0, 7));
      issue_lat = 2'($urandom);
      issue_valid = m_stall() ? ($urandom_range(0, 15) == 0) : 1'($urandom);
      check_all();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
